// File: rtl/sbox_mux_sequencer.sv
// Sequences the eight DES S-box lookups of one round through a single shared mux bank.
// Optional feature: define SBOX_SEQ_PIPE_EN to register mux_y before it is written back.
module sbox_mux_sequencer #(
    parameter int unsigned NUM_BOX = 8,
    parameter int unsigned BOX_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6*NUM_BOX-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NUM_BOX-1:0]   out_data,
    output logic                   mux_en,
    output logic [BOX_W-1:0]       mux_box,
    output logic [5:0]             mux_sel,
    input  logic [3:0]             mux_y,
    output logic                   busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [6*NUM_BOX-1:0]   data_q, data_d;
    logic [BOX_W-1:0]       k_q, k_d;
    logic [4*NUM_BOX-1:0]   out_data_q, out_data_d;
    logic                   mux_en_q, mux_en_d;
    logic [BOX_W-1:0]       mux_box_q, mux_box_d;
    logic [5:0]             mux_sel_q, mux_sel_d;
    logic                   last_box;
`ifdef SBOX_SEQ_PIPE_EN
    logic [3:0]             y_q, y_d;
    logic                   wr_q, wr_d;
    logic [BOX_W-1:0]       wr_idx_q, wr_idx_d;
`endif

    // Slice out box idx and reorder to DES row*16 + column.
    function automatic logic [5:0] box_sel(input logic [6*NUM_BOX-1:0] w,
                                           input logic [BOX_W-1:0] idx);
        logic [5:0] s;
        s = '0;
        for (int b = 0; b < NUM_BOX; b++) begin
            if (idx == BOX_W'(b)) s = w[6*(NUM_BOX-1-b) +: 6];
        end
        return {s[5], s[0], s[4:1]};
    endfunction

    function automatic logic [4*NUM_BOX-1:0] put_slot(input logic [4*NUM_BOX-1:0] w,
                                                      input logic [BOX_W-1:0] idx,
                                                      input logic [3:0] y);
        logic [4*NUM_BOX-1:0] r;
        r = w;
        for (int b = 0; b < NUM_BOX; b++) begin
            if (idx == BOX_W'(b)) r[4*(NUM_BOX-1-b) +: 4] = y;
        end
        return r;
    endfunction

    assign last_box = (k_q == BOX_W'(NUM_BOX - 1));

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        mux_en_d   = 1'b0;
        mux_box_d  = mux_box_q;
        mux_sel_d  = mux_sel_q;
`ifdef SBOX_SEQ_PIPE_EN
        y_d        = y_q;
        wr_d       = 1'b0;
        wr_idx_d   = wr_idx_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d    = StRun;
                    data_d     = in_data;
                    k_d        = '0;
                    out_data_d = '0;
                    mux_en_d   = 1'b1;
                    mux_box_d  = '0;
                    mux_sel_d  = box_sel(in_data, '0);
                end
            end
            StRun: begin
`ifdef SBOX_SEQ_PIPE_EN
                if (wr_q) out_data_d = put_slot(out_data_q, wr_idx_q, y_q);
                if (mux_en_q) begin
                    y_d      = mux_y;
                    wr_d     = 1'b1;
                    wr_idx_d = k_q;
                    if (!last_box) begin
                        k_d       = k_q + 1'b1;
                        mux_en_d  = 1'b1;
                        mux_box_d = k_q + 1'b1;
                        mux_sel_d = box_sel(data_q, k_q + 1'b1);
                    end
                end else begin
                    // Drain cycle: last registered lookup was just written.
                    state_d = StDone;
                end
`else
                out_data_d = put_slot(out_data_q, k_q, mux_y);
                if (last_box) begin
                    state_d = StDone;
                end else begin
                    k_d       = k_q + 1'b1;
                    mux_en_d  = 1'b1;
                    mux_box_d = k_q + 1'b1;
                    mux_sel_d = box_sel(data_q, k_q + 1'b1);
                end
`endif
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            k_q        <= '0;
            out_data_q <= '0;
            mux_en_q   <= 1'b0;
            mux_box_q  <= '0;
            mux_sel_q  <= '0;
`ifdef SBOX_SEQ_PIPE_EN
            y_q        <= '0;
            wr_q       <= 1'b0;
            wr_idx_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            mux_en_q   <= mux_en_d;
            mux_box_q  <= mux_box_d;
            mux_sel_q  <= mux_sel_d;
`ifdef SBOX_SEQ_PIPE_EN
            y_q        <= y_d;
            wr_q       <= wr_d;
            wr_idx_q   <= wr_idx_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = out_data_q;
    assign mux_en    = mux_en_q;
    assign mux_box   = mux_box_q;
    assign mux_sel   = mux_sel_q;

endmodule

// File: tb/tb_sbox_mux_sequencer.sv
// Directed bench for sbox_mux_sequencer with a box-index / DES S1 mux bank model.
// Follows SBOX_SEQ_PIPE_EN for latency and interval expectations.
module tb_sbox_mux_sequencer;

`ifdef SBOX_SEQ_PIPE_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif
    localparam int II = LAT + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        mux_en;
    logic [2:0]  mux_box;
    logic [5:0]  mux_sel;
    logic [3:0]  mux_y;
    logic        busy;

    logic         use_s1;
    logic [255:0] s1_flat;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    sbox_mux_sequencer #(.NUM_BOX(8), .BOX_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mux_en    (mux_en),
        .mux_box   (mux_box),
        .mux_sel   (mux_sel),
        .mux_y     (mux_y),
        .busy      (busy)
    );

    // Mux bank model: box 0 may use the real S1 table, otherwise echo the box index.
    always_comb begin
        mux_y = {1'b0, mux_box};
        if (use_s1 && mux_box == 3'd0) mux_y = s1_flat[255 - 4*int'(mux_sel) -: 4];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a word in IDLE; returns at the negedge just after the accepting edge.
    task automatic send_word(input logic [47:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        int            cnt;
        int            seen;
        logic [5:0]    exp_sel [8];
        logic [47:0]   words [3];
        logic [31:0]   exp_res [3];
        logic [31:0]   res [3];
        int            acc_cyc [3];
        int            naccept, nres, idx, cyc;
        bit            acc_pending;

        s1_flat   = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175BE3A06D;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        use_s1    = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_mux", {mux_en, mux_box, mux_sel}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Box ordering, latency and single-cycle out_valid.
        send_word(48'h0);
        wait_out(cnt);
        check_eq("order_latency", cnt, LAT);
        check_eq("order_data", out_data, 32'h01234567);
        @(negedge clk);
        check_eq("order_one_cycle", out_valid, 0);
        check_eq("order_idle", in_ready, 1);

        // Address remap with S1.
        use_s1 = 1'b1;
        send_word({6'b011011, 42'b0});
        check_eq("remap_en", mux_en, 1);
        check_eq("remap_box", mux_box, 0);
        check_eq("remap_sel", mux_sel, 6'h1D);
        wait_out(cnt);
        check_eq("remap_data", out_data, 32'h51234567);
        @(negedge clk);
        use_s1 = 1'b0;

        // Per-box select sequencing and hold after RUN.
        exp_sel = '{6'h10, 6'h20, 6'h0F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h39};
        send_word({6'b000001, 6'b100000, 6'b011110, 24'b0, 6'b110011});
        for (int b = 0; b < 8; b++) begin
            check_eq($sformatf("seq_box%0d", b), {mux_en, mux_box, mux_sel}, {1'b1, 3'(b), exp_sel[b]});
            @(negedge clk);
        end
        check_eq("seq_en_off", mux_en, 0);
        check_eq("seq_hold", {mux_box, mux_sel}, {3'd7, 6'h39});
        wait_out(cnt);
        @(negedge clk);

        // Backpressure with a competing second word.
        out_ready = 1'b0;
        send_word(48'h0);
        wait_out(cnt);
        check_eq("bp_latency", cnt, LAT);
        in_valid = 1'b1;
        in_data  = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("bp_hold%0d", i), {out_valid, in_ready, out_data},
                     {1'b1, 1'b0, 32'h01234567});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_idle", {in_ready, busy, out_valid}, 3'b100);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_second", {busy, mux_en, mux_box, mux_sel}, {1'b1, 1'b1, 3'd0, 6'h3F});
        wait_out(cnt);
        check_eq("bp_second_data", out_data, 32'h01234567);
        @(negedge clk);

        // Asynchronous reset at box 3.
        send_word(48'h0);
        repeat (3) @(negedge clk);
        check_eq("rstmid_box", mux_box, 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid_ctl", {in_ready, busy, out_valid}, 3'b100);
        check_eq("rstmid_data", out_data, 0);
        check_eq("rstmid_mux", {mux_en, mux_box, mux_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_eq("rstmid_no_valid", seen, 0);
        send_word(48'h0);
        wait_out(cnt);
        check_eq("rstmid_after", out_data, 32'h01234567);
        @(negedge clk);

        // Back-to-back with in_valid and out_ready held high.
        use_s1     = 1'b1;
        words      = '{{6'b011011, 42'b0}, 48'h0, {6'b111111, 42'b0}};
        exp_res    = '{32'h51234567, 32'hE1234567, 32'hD1234567};
        res        = '{32'h0, 32'h0, 32'h0};
        acc_cyc    = '{0, 0, 0};
        naccept    = 0;
        nres       = 0;
        idx        = 0;
        cyc        = 0;
        acc_pending = 0;
        in_data    = words[0];
        in_valid   = 1'b1;
        while (cyc < 80 && nres < 3) begin
            if (acc_pending) begin
                acc_pending = 0;
                idx++;
                if (idx < 3) in_data = words[idx];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (nres < 3) res[nres] = out_data;
                nres++;
            end
            if (in_valid && in_ready) begin
                if (naccept < 3) acc_cyc[naccept] = cyc;
                naccept++;
                acc_pending = 1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("b2b_accepts", naccept, 3);
        check_eq("b2b_gap1", acc_cyc[1] - acc_cyc[0], II);
        check_eq("b2b_gap2", acc_cyc[2] - acc_cyc[1], II);
        for (int i = 0; i < 3; i++) check_eq($sformatf("b2b_res%0d", i), res[i], exp_res[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sbox_mux_sequencer.md
# sbox_mux_sequencer

Time-multiplexes one shared S-box lookup mux bank (a 64:1 mux tree per output bit) across the eight S-box lookups of a DES round. Accepts the 48-bit post-XOR expansion word and drives one 6-bit select and box index per cycle into the shared bank. Collects the returned 4-bit values into the 32-bit S-box layer output. Sits between the round key-mix XOR and the P-permutation, replacing eight parallel S-box instances with one.

## Interface
- `NUM_BOX`, default 8: number of S-box lookups per transaction.
- `BOX_W`, default 3: width of the box index; must equal clog2(`NUM_BOX`).
- Select width is fixed at 6 and lookup width is fixed at 4; these are not parameters.

- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: input word valid.
- `in_ready`, output, 1: block can accept a word.
- `in_data`, input, 6*NUM_BOX: expansion ⊕ subkey word. Box k uses bits [6*NUM_BOX-1-6k -: 6].
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, 4*NUM_BOX: S-box layer result. Box k writes bits [4*NUM_BOX-1-4k -: 4].
- `mux_en`, output, 1: high when the mux bank is being driven with a live lookup.
- `mux_box`, output, BOX_W: selects which S-box table feeds the mux data input.
- `mux_sel`, output, 6: mux tree select.
- `mux_y`, input, 4: combinational lookup result from the mux bank.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- **States and transitions:**
  - **IDLE** → RUN on `in_valid & in_ready`.
  - **RUN** → DONE after the last lookup is captured.
  - **DONE** → IDLE on `out_ready`.
- **`in_ready`** = (state == IDLE), decoded directly from state. Input is never accepted in RUN or DONE.
- **On accept:**
  - `in_data` is latched into an internal register.
  - Box counter k is set to 0.
  - `out_data` is cleared to 0.
- **Each RUN cycle (box k):**
  - `mux_en` = 1 and `mux_box` = k.
  - Let s = slice k. Then `mux_sel` = {s[5], s[0], s[4], s[3], s[2], s[1]}, i.e. DES row×16 + column.
  - `mux_y` is written into slot k of `out_data`. Slot write, not shift.
  - k increments.
- **Last box:** when k = NUM_BOX-1 is captured, the FSM moves to DONE.
- **Outside RUN:** `mux_en` = 0. `mux_box` and `mux_sel` hold their last values.
- **DONE:**
  - `out_valid` = 1.
  - `out_data` is held stable until `out_ready` is sampled high.
  - `out_valid` is never dropped without a handshake.
- **Reset, including mid-RUN or mid-DONE:** the transaction is discarded, the FSM returns to IDLE, and no partial result is emitted.
- **Reset values:**
  - state = IDLE, `in_ready` = 1, `busy` = 0.
  - `out_valid` = 0, `out_data` = 0.
  - `mux_en` = 0, `mux_box` = 0, `mux_sel` = 0.
  - internal data register = 0, k = 0.

## Timing
- **Accept:** a handshake at rising edge T means RUN occupies cycles T+1 … T+NUM_BOX.
- **Result:** `out_valid` is high from cycle T+NUM_BOX+1, which is T+9 for the default.
- **Throughput:** with `out_ready` tied high, DONE lasts one cycle and IDLE one cycle, so the minimum initiation interval is NUM_BOX+2 = 10 cycles.
- **Mux bank path:** `mux_box`, `mux_sel` and `mux_en` are registered. `mux_y` is sampled on the same cycle the select is presented, so the mux bank sits in one combinational path.
- **Backpressure:** `out_ready` low stalls indefinitely in DONE with all outputs static.
- **Simultaneous events:** `in_valid` asserted while in DONE is ignored. Because `in_ready` = 0, the upstream must hold the word until IDLE.

## Configuration
- **`SBOX_SEQ_PIPE_EN` defined:**
  - `mux_y` is registered, and the registered value is written to slot k-1 on the following cycle.
  - RUN lasts NUM_BOX+1 cycles. The final drain cycle has `mux_en` = 0.
  - `out_valid` rises at T+NUM_BOX+2 and the initiation interval becomes NUM_BOX+3 (11).
  - Use this when the mux tree does not close timing in one cycle.
- **Undefined:** same-cycle capture as described above, with latency NUM_BOX+1.

## Test plan
- **Box ordering:** the bench mux model returns `mux_box` as `mux_y`. With `in_data` = 48'h0 and `out_ready` = 1 → `out_data` = 32'h01234567, `out_valid` at T+9 for exactly one cycle.
- **Address remap:** slice 0 = 6'b011011 with the DES S1 table model:
  - first RUN cycle shows `mux_box` = 0, `mux_sel` = 6'h1D, `mux_en` = 1;
  - `out_data`[31:28] = 4'h5.
- **Backpressure:** hold `out_ready` low for 5 cycles after `out_valid`, and pulse `in_valid` with a second word → `out_data` stable, `in_ready` = 0, second word not taken. On `out_ready` = 1 the block returns to IDLE and accepts the second word the next cycle.
- **Reset mid-operation:** deassert `rst_n` during RUN at k = 3 → outputs take reset values asynchronously and `out_valid` never rises. A subsequent transaction produces the correct full result.
- **Back-to-back:** `in_valid` and `out_ready` tied high for 3 words → accepts spaced exactly 10 cycles apart, with results in order.
- **`SBOX_SEQ_PIPE_EN` build:** repeat scenario 1 → identical `out_data`, `out_valid` at T+10, interval 11, `mux_en` low on the drain cycle.
